// File: rtl/sc_decoder.sv
// -----------------------------------------------------------------------------
// sc_decoder
//   Recovers a binary value from a frame of stochastic-computing words. Every
//   accepted beat adds the number of ones in its word to an accumulator. A frame
//   closes on in_last or when FRAME beats have been accepted, whichever comes
//   first. The scaled and saturated result is then presented until it is
//   consumed. A frame that closes early is scaled as if it were padded with
//   all-zero beats up to FRAME beats.
//
// Ports
//   clk           sole clock, rising edge
//   rst_n         asynchronous active-low reset
//   in_bitstream  one stochastic word (BITSTREAM bits)
//   in_valid      in_bitstream is valid
//   in_last       final beat of the frame (qualified by in_valid)
//   in_ready      decoder can accept a beat
//   out_data      recovered value (QUANT bits)
//   out_beats     beats accumulated into out_data (1..FRAME)
//   out_short     frame closed by in_last before FRAME beats
//   out_valid     out_data / out_beats / out_short are valid
//   out_ready     consumer accepts the result
// -----------------------------------------------------------------------------
module sc_decoder #(
    parameter int BITSTREAM = 64,
    parameter int QUANT     = 8,
    parameter int FRAME     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [BITSTREAM-1:0]       in_bitstream,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [QUANT-1:0]           out_data,
    output logic [$clog2(FRAME):0]     out_beats,
    output logic                       out_short,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int ACC_W = $clog2(FRAME * BITSTREAM) + 1;
    localparam int CNT_W = $clog2(FRAME) + 1;
    localparam int POP_W = $clog2(BITSTREAM) + 1;
    localparam int SHIFT = $clog2(FRAME * BITSTREAM);
    localparam int SCL_W = ACC_W + QUANT;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state, state_n;
    logic [ACC_W-1:0]   acc, acc_n, sum;
    logic [CNT_W-1:0]   cnt, cnt_n, cnt_inc;
    logic [POP_W-1:0]   pop;
    logic [SCL_W-1:0]   scaled;
    logic [QUANT-1:0]   result;
    logic               accept, full, load;

    // Only the number of ones matters, so bit order has no effect on the result.
    always_comb begin
        pop = '0;
        for (int i = 0; i < BITSTREAM; i++) begin
            pop = pop + POP_W'(in_bitstream[i]);
        end
    end

    assign in_ready  = (state == ACCUM) || out_ready;
    assign out_valid = (state == HOLD);
    assign accept    = in_valid && in_ready;

    assign sum     = acc + ACC_W'(pop);
    assign cnt_inc = cnt + CNT_W'(1);
    assign full    = (cnt_inc == CNT_W'(FRAME));

    // Scaling against the full-frame capacity is what zero-pads short frames.
    // Anything above the QUANT-bit range saturates to all ones.
    assign scaled = (SCL_W'(sum) << QUANT) >> SHIFT;
    assign result = (|scaled[SCL_W-1:QUANT]) ? '1 : scaled[QUANT-1:0];

    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        load    = 1'b0;
        if (state == HOLD && out_ready) begin
            state_n = ACCUM;
        end
        // acc/cnt are already zero in HOLD (they are cleared on close), so a
        // beat accepted while the result is consumed starts the next frame.
        if (accept) begin
            if (in_last || full) begin
                state_n = HOLD;
                acc_n   = '0;
                cnt_n   = '0;
                load    = 1'b1;
            end else begin
                acc_n = sum;
                cnt_n = cnt_inc;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, whatever order the statements are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_beats <= '0;
            out_short <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            // The result registers change only when a frame closes, so they
            // stay stable while a result waits for out_ready.
            if (load) begin
                out_data  <= result;
                out_beats <= cnt_inc;
                out_short <= !full;
            end
        end
    end

endmodule

// File: tb/tb_sc_decoder.sv
module tb_sc_decoder;

    localparam int BITSTREAM = 64;
    localparam int QUANT     = 8;
    localparam int FRAME     = 8;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [BITSTREAM-1:0]   in_bitstream;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic [QUANT-1:0]       out_data;
    logic [$clog2(FRAME):0] out_beats;
    logic                   out_short;
    logic                   out_valid;
    logic                   out_ready;

    int n_checks = 0;
    int n_pass   = 0;

    sc_decoder #(.BITSTREAM(BITSTREAM), .QUANT(QUANT), .FRAME(FRAME)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_bitstream (in_bitstream),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_beats    (out_beats),
        .out_short    (out_short),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ones;       // ones in every beat of the frame
        int nbeats;     // beats driven
        bit last;       // in_last on the final driven beat
        int exp_data;
        int exp_beats;
        bit exp_short;
    } frame_t;

    frame_t vec[8];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Word with exactly 'ones' set bits at random positions.
    function automatic logic [BITSTREAM-1:0] make_word(input int ones);
        logic [BITSTREAM-1:0] w = '0;
        int cnt = 0;
        while (cnt < ones) begin
            int idx = $urandom_range(BITSTREAM - 1, 0);
            if (!w[idx]) begin
                w[idx] = 1'b1;
                cnt++;
            end
        end
        return w;
    endfunction

    // Drives one beat for one clock; returns #1 after the edge.
    task automatic send_beat(input int ones, input bit last);
        in_valid     = 1'b1;
        in_bitstream = make_word(ones);
        in_last      = last;
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_bitstream = '0;
    endtask

    task automatic check_result(input string name, input int d, input int b, input int s);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_data"},  out_data,  d);
        check({name, "_beats"}, out_beats, b);
        check({name, "_short"}, out_short, s);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ones, beats, last, data, beats, short
        vec[0] = '{32, 8, 1'b1, 128, 8, 1'b0};
        vec[1] = '{64, 8, 1'b0, 255, 8, 1'b0};
        vec[2] = '{ 0, 8, 1'b1,   0, 8, 1'b0};
        vec[3] = '{64, 2, 1'b1,  64, 2, 1'b1};
        vec[4] = '{16, 8, 1'b0,  64, 8, 1'b0};
        vec[5] = '{10, 3, 1'b1,  15, 3, 1'b1};
        vec[6] = '{64, 1, 1'b1,  32, 1, 1'b1};
        vec[7] = '{40, 8, 1'b0, 160, 8, 1'b0};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_last      = 1'b0;
        in_bitstream = '0;
        out_ready    = 1'b1;

        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data",  out_data,  0);
        check("rst_beats", out_beats, 0);
        check("rst_short", out_short, 0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Table-driven frames, consumer always ready.
        for (int v = 0; v < 8; v++) begin
            out_ready = 1'b1;
            for (int b = 0; b < vec[v].nbeats; b++) begin
                send_beat(vec[v].ones, vec[v].last && (b == vec[v].nbeats - 1));
                if (b < vec[v].nbeats - 1)
                    check($sformatf("v%0d_b%0d_not_valid", v, b), out_valid, 0);
            end
            check_result($sformatf("v%0d", v), vec[v].exp_data, vec[v].exp_beats, vec[v].exp_short);
            idle_cycle();
            check($sformatf("v%0d_consumed", v), out_valid, 0);
        end

        // 9 beats without in_last: closes after beat 8, beat 9 opens next frame.
        for (int b = 0; b < 9; b++) begin
            send_beat(64, 1'b0);
            if (b == 7) check_result("ovf_f1", 255, 8, 0);
        end
        check("ovf_beat9_valid", out_valid, 0);
        // 7 more zero beats, in_last on beat 8 coincides with the count limit.
        for (int b = 0; b < 7; b++) send_beat(0, b == 6);
        check_result("ovf_f2", 32, 8, 0);
        idle_cycle();
        check("ovf_single_frame_a", out_valid, 0);
        idle_cycle();
        check("ovf_single_frame_b", out_valid, 0);

        // Back-pressure: result held for 5 cycles while a beat is offered.
        out_ready = 1'b0;
        for (int b = 0; b < 8; b++) send_beat(32, b == 7);
        in_valid     = 1'b1;
        in_bitstream = make_word(64);
        in_last      = 1'b0;
        for (int c = 0; c < 5; c++) begin
            idle_cycle();
            check_result($sformatf("hold_c%0d", c), 128, 8, 0);
            check($sformatf("hold_c%0d_in_ready", c), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("hold_release_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("hold_consumed", out_valid, 0);
        send_beat(64, 1'b1);
        check_result("hold_next", 64, 2, 1);
        // Consume and close a 1-beat frame in the same cycle: straight back to HOLD.
        send_beat(32, 1'b1);
        check_result("rehold", 16, 1, 1);
        idle_cycle();
        check("rehold_consumed", out_valid, 0);

        // Asynchronous reset while a result is pending.
        out_ready = 1'b0;
        for (int b = 0; b < 8; b++) send_beat(64, 1'b0);
        check("prerst_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_hold_valid", out_valid, 0);
        check("arst_hold_data",  out_data,  0);
        check("arst_hold_beats", out_beats, 0);
        @(posedge clk);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("arst_hold_in_ready", in_ready, 1);

        // Asynchronous reset mid-frame discards the partial accumulation.
        for (int b = 0; b < 3; b++) send_beat(64, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_mid_valid", out_valid, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_mid_in_ready", in_ready, 1);
        for (int b = 0; b < 8; b++) send_beat(16, 1'b0);
        check_result("post_rst", 64, 8, 0);
        idle_cycle();
        check("post_rst_consumed", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
